load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_SIZE, default 1024, data-memory depth in 32-bit words; memory word-address width is AW = $clog2(MEM_SIZE).
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_valid  input  1  request present.
REQ-005 o_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 i_store  input  1  1 = store, 0 = load.
REQ-007 i_funct3  input  3  RV32 width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 i_addr  input  32  byte address.
REQ-009 i_wdata  input  32  store data; byte/half taken from low bits.
REQ-010 o_done  output  1  one-cycle pulse, request complete.
REQ-011 o_err  output  1  valid with o_done; request rejected (misaligned, out of range, illegal funct3).
REQ-012 o_rdata  output  32  load result, valid with o_done; zero for stores and errors.
REQ-013 o_mem_we  output  1  data-memory write enable.
REQ-014 o_mem_addr  output  AW  data-memory word address.
REQ-015 o_mem_wdata  output  32  data-memory write word.
REQ-016 i_mem_rdata  input  32  data-memory read word; combinational from o_mem_addr.

Function
REQ-017 FSM states: IDLE, READ, WRITE, DONE; the unit handles exactly one request at a time.
REQ-018 Accept when i_valid && o_ready; latch i_store, i_funct3, i_addr, i_wdata; inputs are ignored outside IDLE.
REQ-019 Error on accept: halfword with addr[0]=1, word with addr[1:0]!=0, addr[31:2] >= MEM_SIZE, store funct3 not in {000,001,010}, or load funct3 in {011,110,111}.
REQ-020 Error request: IDLE -> DONE with o_err=1; no memory write ever issued.
REQ-021 Valid load or SB/SH: IDLE -> READ; valid SW: IDLE -> WRITE.
REQ-022 READ: drive o_mem_addr = addr[AW+1:2]; register i_mem_rdata this cycle; load -> DONE, SB/SH -> WRITE.
REQ-023 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-024 WRITE: o_mem_we=1 for exactly this cycle; SW writes i_wdata; SB/SH write the captured word with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0]; -> DONE.
REQ-025 DONE: o_done=1, o_err and o_rdata valid for that cycle only; -> IDLE.
REQ-026 Latency from accept edge T: error done in T+1; load and SW in T+2; SB/SH in T+3; next accept earliest in the cycle after o_done.
REQ-027 o_mem_we is 0 in every state except WRITE; o_mem_addr is held stable from READ through WRITE.
REQ-028 Back-to-back requests: a store followed by a load to the same word returns the newly written value.

Reset
REQ-029 When i_rst_n is low at a clock edge: state=IDLE, o_ready=1, o_done=0, o_err=0, o_rdata=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, and all latched request fields are cleared.
REQ-030 Reset asserted in READ or WRITE aborts the request: no o_done is produced, and no write occurs on that edge or any later edge.
REQ-031 Reset has priority over an i_valid presented on the same edge.

Verification
REQ-032 Memory word 4 = 0x8000_F0FF; LB addr 0x10 -> o_rdata 0xFFFF_FFFF; LBU addr 0x11 -> 0x0000_00F0; LH addr 0x12 -> 0xFFFF_8000; LHU addr 0x12 -> 0x0000_8000; each with o_done at T+2.
REQ-033 Word 2 = 0x1122_3344; SB addr 0x09 with wdata 0xAB -> word 2 = 0x1122_AB44 and o_mem_we high for exactly one cycle, done at T+3; then SH addr 0x0A with wdata 0xBEEF -> word 2 = 0xBEEF_AB44.
REQ-034 SW addr 0x0C with wdata 0xDEAD_BEEF -> done at T+2; immediate LW addr 0x0C -> 0xDEAD_BEEF.
REQ-035 LW addr 0x06, SH addr 0x03, and LW addr 4*MEM_SIZE -> o_done and o_err at T+1, o_rdata 0, o_mem_we never asserted, memory unchanged.
REQ-036 i_rst_n pulled low during READ of an SB -> no o_mem_we and no o_done; after release o_ready=1 and the target word is unchanged.
REQ-037 i_valid held high continuously with new requests -> exactly one accept per o_done, each accept in the cycle after the previous o_done.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request and data-memory bundle between a requester and the load/store unit.
// slave modport: the load/store unit; master modport: the requester plus the memory it owns.
// Signal names keep the unit's point of view (i_* into the unit, o_* out of the unit).
interface load_store_unit_if #(
    parameter int MEM_SIZE = 1024
);
    localparam int AW = $clog2(MEM_SIZE);

    // request side
    logic          i_valid;
    logic          o_ready;
    logic          i_store;
    logic [2:0]    i_funct3;
    logic [31:0]   i_addr;
    logic [31:0]   i_wdata;
    logic          o_done;
    logic          o_err;
    logic [31:0]   o_rdata;

    // data-memory side (read data is combinational from o_mem_addr)
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata;

    modport slave (
        input  i_valid, i_store, i_funct3, i_addr, i_wdata, i_mem_rdata,
        output o_ready, o_done, o_err, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_valid, i_store, i_funct3, i_addr, i_wdata, i_mem_rdata,
        input  o_ready, o_done, o_err, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request at a time against a word-wide memory, byte/half via read-modify-write.
// Latency from accept: error 1 cycle, load/SW 2 cycles, SB/SH 3 cycles until the o_done pulse.
// Backpressure: o_ready is high only in IDLE; requests are ignored while one is in flight.
// Ports: i_clk, i_rst_n (synchronous, active-low); lsu (slave modport) carries the request
//        handshake (i_valid/o_ready/o_done/o_err/o_rdata) and the memory port (o_mem_*/i_mem_rdata).
module load_store_unit #(
    parameter int MEM_SIZE = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    load_store_unit_if.slave      lsu
);
    localparam int AW = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic          store_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;     // only word index and byte offset are needed after accept
    logic [31:0]   wdata_q;
    logic [31:0]   word_q;     // memory word captured in READ
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic          f3_ok;
    logic          misaligned;
    logic          out_of_range;

    assign accept = lsu.i_valid && (state_q == IDLE);

    // request legality, evaluated on the raw inputs at accept time
    always_comb begin
        if (lsu.i_store) begin
            f3_ok = (lsu.i_funct3 == 3'b000) || (lsu.i_funct3 == 3'b001) || (lsu.i_funct3 == 3'b010);
        end else begin
            f3_ok = !((lsu.i_funct3 == 3'b011) || (lsu.i_funct3 == 3'b110) || (lsu.i_funct3 == 3'b111));
        end
        misaligned   = ((lsu.i_funct3[1:0] == 2'b01) && lsu.i_addr[0]) ||
                       ((lsu.i_funct3[1:0] == 2'b10) && (lsu.i_addr[1:0] != 2'b00));
        out_of_range = {2'b00, lsu.i_addr[31:2]} >= 32'(MEM_SIZE);
        req_err      = !f3_ok || misaligned || out_of_range;
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsu.i_valid) begin
                    if (req_err) begin
                        state_d = DONE;
                    end else if (lsu.i_store && (lsu.i_funct3[1:0] == 2'b10)) begin
                        state_d = WRITE;   // full-word store needs no read
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = store_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request fields and captured memory word
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                store_q  <= lsu.i_store;
                funct3_q <= lsu.i_funct3;
                addr_q   <= lsu.i_addr[AW+1:0];
                wdata_q  <= lsu.i_wdata;
                err_q    <= req_err;
            end
            if (state_q == READ) begin
                word_q <= lsu.i_mem_rdata;
            end
        end
    end

    // outputs
    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [31:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;
    logic [31:0] st_word;

    always_comb begin
        sh_b   = {addr_q[1:0], 3'b000};
        sh_h   = {addr_q[1], 4'b0000};
        lane_b = word_q >> sh_b;
        lane_h = addr_q[1] ? word_q[31:16] : word_q[15:0];

        case (funct3_q)
            3'b000:  ld_val = {{24{lane_b[7]}}, lane_b[7:0]};
            3'b001:  ld_val = {{16{lane_h[15]}}, lane_h};
            3'b010:  ld_val = word_q;
            3'b100:  ld_val = {24'h0, lane_b[7:0]};
            3'b101:  ld_val = {16'h0, lane_h};
            default: ld_val = 32'h0;
        endcase

        // sub-word stores splice wdata into the word read in READ
        case (funct3_q[1:0])
            2'b00:   st_word = (word_q & ~(32'h0000_00FF << sh_b)) | ({24'h0, wdata_q[7:0]} << sh_b);
            2'b01:   st_word = (word_q & ~(32'h0000_FFFF << sh_h)) | ({16'h0, wdata_q[15:0]} << sh_h);
            default: st_word = wdata_q;
        endcase

        lsu.o_ready     = (state_q == IDLE);
        lsu.o_done      = (state_q == DONE);
        lsu.o_err       = (state_q == DONE) && err_q;
        lsu.o_rdata     = ((state_q == DONE) && !err_q && !store_q) ? ld_val : 32'h0;
        // reset in WRITE must suppress the write on that same edge
        lsu.o_mem_we    = (state_q == WRITE) && i_rst_n;
        lsu.o_mem_addr  = addr_q[AW+1:2];
        lsu.o_mem_wdata = (state_q == WRITE) ? st_word : 32'h0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-array memory model, hand-computed load/store vectors,
// error cases, reset abort and continuous-valid throughput.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_load_store_unit;
    localparam int MEM_SIZE = 1024;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   we_cnt;
    int   done_cnt;

    logic [31:0] mem [MEM_SIZE];

    load_store_unit_if #(.MEM_SIZE(MEM_SIZE)) bus ();

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .lsu     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_mem_rdata = mem[bus.o_mem_addr];

    always @(posedge clk) begin
        if (bus.o_mem_we) begin
            mem[bus.o_mem_addr] <= bus.o_mem_wdata;
            we_cnt = we_cnt + 1;
        end
        if (bus.o_done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from a falling edge; wait for o_done and check latency/err/rdata/write count.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int we0;
        int lat;
        we0 = we_cnt;
        lat = 0;
        chk({tag, "_ready"}, {31'b0, bus.o_ready}, 32'd1);
        bus.i_valid  = 1'b1;
        bus.i_store  = st;
        bus.i_funct3 = f3;
        bus.i_addr   = addr;
        bus.i_wdata  = wd;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        bus.i_wdata = 32'h0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.o_done) begin
                lat = n;
                chk({tag, "_err"}, {31'b0, bus.o_err}, {31'b0, exp_err});
                chk({tag, "_rdata"}, bus.o_rdata, exp_rd);
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        @(negedge clk);
        chk({tag, "_we"}, we_cnt - we0, (st && !exp_err) ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rd;
    } ld_t;

    ld_t         seq [3];
    int          acc_c [$];
    int          done_c [$];
    logic [31:0] rd_q [$];
    int          idx;
    int          we0;
    int          dn0;

    initial begin
        checks = 0; errors = 0; we_cnt = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_store = 1'b0; bus.i_funct3 = 3'b0;
        bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 32'h0;
        #1;
        mem[2] <= 32'h1122_3344;
        mem[4] <= 32'h8000_F0FF;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
        chk("rst_done",  {31'b0, bus.o_done}, 32'd0);
        chk("rst_err",   {31'b0, bus.o_err}, 32'd0);
        chk("rst_rdata", bus.o_rdata, 32'h0);
        chk("rst_we",    {31'b0, bus.o_mem_we}, 32'd0);
        chk("rst_maddr", {22'b0, bus.o_mem_addr}, 32'h0);
        chk("rst_mwdata", bus.o_mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // loads from word 4 = 0x8000_F0FF
        do_req("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hFFFF_FFFF);
        do_req("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 2, 1'b0, 32'h0000_00F0);
        do_req("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_8000);
        do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 32'h0000_8000);
        do_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 1'b0, 32'h0000_F0FF);
        do_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h8000_F0FF);

        // sub-word stores to word 2 = 0x1122_3344
        do_req("sb09", 1'b1, 3'b000, 32'h09, 32'h0000_00AB, 3, 1'b0, 32'h0);
        chk("sb09_mem", mem[2], 32'h1122_AB44);
        do_req("sh0a", 1'b1, 3'b001, 32'h0A, 32'h1234_BEEF, 3, 1'b0, 32'h0);
        chk("sh0a_mem", mem[2], 32'hBEEF_AB44);

        // word store then immediate load of the same word
        do_req("sw0c", 1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
        do_req("lw0c", 1'b0, 3'b010, 32'h0C, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);

        // rejected requests: done+err after one cycle, no write
        do_req("e_lw06",  1'b0, 3'b010, 32'h06, 32'h0, 1, 1'b1, 32'h0);
        do_req("e_sh03",  1'b1, 3'b001, 32'h03, 32'h5555_5555, 1, 1'b1, 32'h0);
        chk("e_sh03_mem", mem[0], 32'h0);
        do_req("e_lwoor", 1'b0, 3'b010, 32'(4 * MEM_SIZE), 32'h0, 1, 1'b1, 32'h0);
        do_req("e_ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0);
        do_req("e_st100", 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 1, 1'b1, 32'h0);
        chk("e_st100_mem", mem[4], 32'h8000_F0FF);

        // reset during the READ of an SB aborts it; reset beats a concurrent i_valid
        we0 = we_cnt;
        dn0 = done_cnt;
        bus.i_valid = 1'b1; bus.i_store = 1'b1; bus.i_funct3 = 3'b000;
        bus.i_addr = 32'h08; bus.i_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;           // in READ now; i_valid stays high
        @(negedge clk);
        chk("abort_ready", {31'b0, bus.o_ready}, 32'd1);
        chk("abort_maddr", {22'b0, bus.o_mem_addr}, 32'h0);
        @(negedge clk);
        chk("rstprio_ready", {31'b0, bus.o_ready}, 32'd1);
        rst_n = 1'b1;
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_we",    we_cnt - we0, 32'd0);
        chk("abort_done",  done_cnt - dn0, 32'd0);
        chk("abort_ready2", {31'b0, bus.o_ready}, 32'd1);
        chk("abort_mem",   mem[2], 32'hBEEF_AB44);

        // continuous i_valid: one accept per o_done, each right after the previous done
        seq[0] = '{3'b010, 32'h10, 32'h8000_F0FF};
        seq[1] = '{3'b010, 32'h0C, 32'hDEAD_BEEF};
        seq[2] = '{3'b100, 32'h11, 32'h0000_00F0};
        idx = 0;
        bus.i_valid = 1'b1; bus.i_store = 1'b0;
        bus.i_funct3 = seq[0].f3; bus.i_addr = seq[0].addr;
        for (int c = 0; c < 40; c++) begin
            if (bus.o_done) begin
                done_c.push_back(c);
                rd_q.push_back(bus.o_rdata);
                idx++;
                if (idx < 3) begin
                    bus.i_funct3 = seq[idx].f3;
                    bus.i_addr   = seq[idx].addr;
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
            if (bus.i_valid && bus.o_ready) acc_c.push_back(c);
            @(negedge clk);
        end
        chk("bb_nacc",  acc_c.size(), 32'd3);
        chk("bb_ndone", done_c.size(), 32'd3);
        if (acc_c.size() == 3 && done_c.size() == 3) begin
            chk("bb_lat0", done_c[0] - acc_c[0], 32'd2);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("bb_gap%0d", k), acc_c[k+1], done_c[k] + 1);
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("bb_rd%0d", k), rd_q[k], seq[k].rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
